// File: rtl/screen_sequencer.sv
// End-of-round display sequencer: fades the game picture out, shows the winner screen,
// waits for start, then fades back into a freshly reset game.
module screen_sequencer #(
    parameter int FADE_STEP_FRAMES = 1,
    parameter int HOLD_FRAMES      = 120
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic        blank,
    input  logic        p1_dead,
    input  logic        p2_dead,
    input  logic        start,
    input  logic [11:0] game_rgb,
    input  logic [11:0] p1win_rgb,
    input  logic [11:0] p2win_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        game_freeze,
    output logic        game_reset,
    output logic [1:0]  winner
);

    localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [4:0] B_FULL = 5'd16;

    typedef enum logic [2:0] {
        PLAY, FADE_OUT_GAME, FADE_IN_WIN, WIN_HOLD, WIN_WAIT, FADE_OUT_WIN, FADE_IN_GAME
    } state_t;

    state_t              state, next_state;
    logic [4:0]          bright;
    logic [STEP_W-1:0]   step_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                vsync_p0;
    logic                frame_tick, step, hold_done, state_chg;
    logic                fade_dn, fade_up;
    logic [11:0]         src_rgb;

    // (c * b) >> 4 with b in 0..16; the product never exceeds 8 bits
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] b);
        logic [8:0] p;
        p = {5'd0, c} * {4'd0, b};
        return 4'(p >> 4);
    endfunction

    assign frame_tick = vsync_p0 & ~vsync;
    assign step       = frame_tick && (step_cnt == STEP_LAST);
    assign hold_done  = frame_tick && (hold_cnt == HOLD_LAST);
    assign state_chg  = (next_state != state);

    always_comb begin
        next_state = state;
        case (state)
            PLAY:          if (p1_dead || p2_dead) next_state = FADE_OUT_GAME;
            FADE_OUT_GAME: if (bright == 5'd0)     next_state = FADE_IN_WIN;
            FADE_IN_WIN:   if (bright == B_FULL)   next_state = WIN_HOLD;
            WIN_HOLD:      if (hold_done)          next_state = WIN_WAIT;
            WIN_WAIT:      if (start)              next_state = FADE_OUT_WIN;
            FADE_OUT_WIN:  if (bright == 5'd0)     next_state = FADE_IN_GAME;
            FADE_IN_GAME:  if (bright == B_FULL)   next_state = PLAY;
            default:                               next_state = PLAY;
        endcase
    end

    always_comb begin
        fade_dn = (state == FADE_OUT_GAME) || (state == FADE_OUT_WIN);
        fade_up = (state == FADE_IN_WIN) || (state == FADE_IN_GAME);
        src_rgb = game_rgb;
        if (state == FADE_IN_WIN || state == WIN_HOLD || state == WIN_WAIT ||
            state == FADE_OUT_WIN) begin
            case (winner)
                2'b01:   src_rgb = p1win_rgb;
                2'b10:   src_rgb = p2win_rgb;
                default: src_rgb = 12'h000;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLAY;
            bright      <= B_FULL;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            vsync_p0    <= 1'b1;
            winner      <= 2'b00;
            game_freeze <= 1'b0;
            game_reset  <= 1'b0;
        end else begin
            state       <= next_state;
            vsync_p0    <= vsync;
            game_freeze <= (next_state != PLAY);
            game_reset  <= (state == FADE_OUT_WIN) && (next_state == FADE_IN_GAME);

            if (state_chg || step)  step_cnt <= '0;
            else if (frame_tick)    step_cnt <= step_cnt + 1'b1;

            if (state_chg || hold_done)                  hold_cnt <= '0;
            else if (frame_tick && state == WIN_HOLD)    hold_cnt <= hold_cnt + 1'b1;

            if (fade_dn && step && bright != 5'd0)        bright <= bright - 5'd1;
            else if (fade_up && step && bright != B_FULL) bright <= bright + 5'd1;

            // dead flags map to the surviving player: {p1_dead,p2_dead} is the winner code
            if (state == PLAY && next_state == FADE_OUT_GAME)
                winner <= {p1_dead, p2_dead};
            else if (state == FADE_OUT_WIN && next_state == FADE_IN_GAME)
                winner <= 2'b00;
        end
    end

    // output stage: one clock after source pixel and blank
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
        end else begin
            red   <= blank ? scale(src_rgb[11:8], bright) : 4'h0;
            green <= blank ? scale(src_rgb[7:4],  bright) : 4'h0;
            blue  <= blank ? scale(src_rgb[3:0],  bright) : 4'h0;
        end
    end

endmodule
